// File: rtl/linebuffer_multitap.sv
`default_nettype none
// ============================================================================
// Module      : linebuffer_multitap
// Description : NUM_TAPS cascaded circular delay lines that share one write
//               pointer. The line length is set at runtime. Every tap is
//               visible on each push, so a stencil engine receives NUM_TAPS
//               rows per written word.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_in       in   clock
//   reset        in   asynchronous reset, active low
//   clk_en       in   global enable; when 0 all datapath state is frozen
//   config_en    in   write config_data to the register chosen by config_addr
//   config_read  in   drive read_data from the register chosen by config_addr
//   config_addr  in   [31:24] selects the register; 0 = CFG
//   config_data  in   CFG: [1:0] mode, [2] tile_en, [15:3] depth
//   read_data    out  combinational config readback
//   data_in      in   write data
//   wen_in       in   push data_in into tap 0
//   flush        in   synchronous clear of the fill state (storage is kept)
//   data_out     out  tap k at [k*WIDTH +: WIDTH]
//   valid_out    out  tap k holds a real delayed word this cycle
//   fill_count   out  saturating count of pushes since the last clear
// ============================================================================
module linebuffer_multitap #(
   parameter int WIDTH     = 16,
   parameter int MAX_DEPTH = 1024,
   parameter int NUM_TAPS  = 3
) (
   input  logic                                      clk_in,
   input  logic                                      reset,
   input  logic                                      clk_en,
   input  logic                                      config_en,
   input  logic                                      config_read,
   input  logic [31:0]                               config_addr,
   input  logic [31:0]                               config_data,
   output logic [31:0]                               read_data,
   input  logic [WIDTH-1:0]                          data_in,
   input  logic                                      wen_in,
   input  logic                                      flush,
   output logic [NUM_TAPS*WIDTH-1:0]                 data_out,
   output logic [NUM_TAPS-1:0]                       valid_out,
   output logic [$clog2(NUM_TAPS*MAX_DEPTH+1)-1:0]   fill_count
);

   localparam int PTR_W  = $clog2(MAX_DEPTH);
   localparam int DEP_W  = $clog2(MAX_DEPTH + 1);
   localparam int FILL_W = $clog2(NUM_TAPS*MAX_DEPTH + 1);

   localparam logic [1:0] MODE_LINEBUF = 2'b00;
   localparam logic [1:0] MODE_BYPASS  = 2'b01;

   // Registered state
   logic [15:0]               cfg_q,   cfg_d;
   logic [PTR_W-1:0]          ptr_q,   ptr_d;
   logic [FILL_W-1:0]         fill_q,  fill_d;
   logic [NUM_TAPS*WIDTH-1:0] dout_q,  dout_d;
   logic [NUM_TAPS-1:0]       valid_q, valid_d;

   // Line storage: one circular buffer per tap, no reset
   logic [WIDTH-1:0] mem [NUM_TAPS][MAX_DEPTH];
   logic [WIDTH-1:0] rd  [NUM_TAPS];

   // Decoded configuration and control
   logic [1:0]        mode;
   logic              tile_en;
   logic [12:0]       depth_raw;
   logic [DEP_W-1:0]  depth_eff;
   logic [FILL_W-1:0] fill_cap;
   logic [FILL_W-1:0] thresh [NUM_TAPS];
   logic              cfg_sel;
   logic              cfg_wr;
   logic              push;
   logic              bypass;
   logic              unused_cfg_bits;

   assign mode      = cfg_q[1:0];
   assign tile_en   = cfg_q[2];
   assign depth_raw = cfg_q[15:3];

   assign cfg_sel = (config_addr[31:24] == 8'd0);
   assign cfg_wr  = config_en & cfg_sel;

   // A config write takes priority over a push in the same cycle.
   assign push   = clk_en & tile_en & wen_in & ~flush & (mode == MODE_LINEBUF) & ~cfg_wr;
   assign bypass = tile_en & (mode == MODE_BYPASS);

   assign unused_cfg_bits = ^{config_data[31:16], config_addr[23:0]};

   // A depth of 0 behaves as 1; anything above MAX_DEPTH is clamped.
   always_comb begin
      if (depth_raw == 13'd0) begin
         depth_eff = DEP_W'(1);
      end else if (32'(depth_raw) > MAX_DEPTH) begin
         depth_eff = DEP_W'(MAX_DEPTH);
      end else begin
         depth_eff = DEP_W'(depth_raw);
      end
   end

   // Tap k holds real data once (k+1)*D words have gone in before this push.
   always_comb begin
      fill_cap = FILL_W'(NUM_TAPS) * FILL_W'(depth_eff);
      for (int k = 0; k < NUM_TAPS; k++) begin
         thresh[k] = FILL_W'(k + 1) * FILL_W'(depth_eff);
      end
   end

   always_comb begin
      for (int k = 0; k < NUM_TAPS; k++) begin
         rd[k] = mem[k][ptr_q];
      end
   end

   always_comb begin
      cfg_d   = cfg_q;
      ptr_d   = ptr_q;
      fill_d  = fill_q;
      dout_d  = dout_q;
      valid_d = valid_q;
      if (cfg_wr) begin
         // Configuration is live even when clk_en is low.
         cfg_d  = config_data[15:0];
         ptr_d  = '0;
         fill_d = '0;
         if (clk_en) begin
            valid_d = '0;
         end
      end else if (clk_en) begin
         if (flush) begin
            ptr_d   = '0;
            fill_d  = '0;
            valid_d = '0;
         end else if (push) begin
            ptr_d = (32'(ptr_q) == 32'(depth_eff) - 1) ? '0 : ptr_q + 1'b1;
            if (fill_q < fill_cap) begin
               fill_d = fill_q + 1'b1;
            end
            for (int k = 0; k < NUM_TAPS; k++) begin
               dout_d[k*WIDTH +: WIDTH] = rd[k];
               valid_d[k]               = (fill_q >= thresh[k]);
            end
         end else if (bypass) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
               dout_d[k*WIDTH +: WIDTH] = data_in;
            end
            valid_d = {NUM_TAPS{wen_in}};
         end else begin
            valid_d = '0;
         end
      end
   end

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         cfg_q   <= '0;
         ptr_q   <= '0;
         fill_q  <= '0;
         dout_q  <= '0;
         valid_q <= '0;
      end else begin
         cfg_q   <= cfg_d;
         ptr_q   <= ptr_d;
         fill_q  <= fill_d;
         dout_q  <= dout_d;
         valid_q <= valid_d;
      end
   end

   // Each tap shifts its old word at ptr into the next tap's buffer.
   always_ff @(posedge clk_in) begin
      if (push) begin
         mem[0][ptr_q] <= data_in;
         for (int k = 1; k < NUM_TAPS; k++) begin
            mem[k][ptr_q] <= rd[k-1];
         end
      end
   end

   assign read_data  = (config_read && cfg_sel) ? {16'h0000, cfg_q} : 32'h0000_0000;
   assign data_out   = dout_q;
   assign valid_out  = valid_q;
   assign fill_count = fill_q;

endmodule
`default_nettype wire

// File: tb/tb_linebuffer_multitap.sv
`default_nettype none
// ============================================================================
// Module      : tb_linebuffer_multitap
// Description : Self-checking bench for linebuffer_multitap. The reference
//               keeps the history of pushed words and derives each tap as the
//               word pushed (k+1)*D writes earlier.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_linebuffer_multitap;

   localparam int WIDTH     = 16;
   localparam int MAX_DEPTH = 1024;
   localparam int NUM_TAPS  = 2;
   localparam int FILL_W    = $clog2(NUM_TAPS*MAX_DEPTH + 1);

   logic                      clk_in;
   logic                      reset;
   logic                      clk_en;
   logic                      config_en;
   logic                      config_read;
   logic [31:0]               config_addr;
   logic [31:0]               config_data;
   logic [31:0]               read_data;
   logic [WIDTH-1:0]          data_in;
   logic                      wen_in;
   logic                      flush;
   logic [NUM_TAPS*WIDTH-1:0] data_out;
   logic [NUM_TAPS-1:0]       valid_out;
   logic [FILL_W-1:0]         fill_count;

   linebuffer_multitap #(
      .WIDTH     (WIDTH),
      .MAX_DEPTH (MAX_DEPTH),
      .NUM_TAPS  (NUM_TAPS)
   ) dut (
      .clk_in      (clk_in),
      .reset       (reset),
      .clk_en      (clk_en),
      .config_en   (config_en),
      .config_read (config_read),
      .config_addr (config_addr),
      .config_data (config_data),
      .read_data   (read_data),
      .data_in     (data_in),
      .wen_in      (wen_in),
      .flush       (flush),
      .data_out    (data_out),
      .valid_out   (valid_out),
      .fill_count  (fill_count)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference state
   logic [15:0]         m_cfg;
   int                  m_n;
   logic [WIDTH-1:0]    m_hist [4096];
   logic [NUM_TAPS-1:0] m_valid;
   logic [WIDTH-1:0]    m_data [NUM_TAPS];
   bit                  m_known [NUM_TAPS];

   function automatic int eff_depth();
      int d;
      d = int'(m_cfg[15:3]);
      if (d == 0) return 1;
      if (d > MAX_DEPTH) return MAX_DEPTH;
      return d;
   endfunction

   function automatic int exp_fill();
      int cap;
      cap = NUM_TAPS * eff_depth();
      return (m_n < cap) ? m_n : cap;
   endfunction

   task automatic model_reset();
      m_cfg   = 16'h0000;
      m_n     = 0;
      m_valid = '0;
      for (int k = 0; k < NUM_TAPS; k++) begin
         m_data[k]  = '0;
         m_known[k] = 1'b1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag);
      check({tag, ".valid"}, 32'(valid_out), 32'(m_valid));
      check({tag, ".fill"}, 32'(fill_count), 32'(exp_fill()));
      for (int k = 0; k < NUM_TAPS; k++) begin
         if (m_known[k]) begin
            check($sformatf("%s.tap%0d", tag, k), 32'(data_out[k*WIDTH +: WIDTH]), 32'(m_data[k]));
         end
      end
   endtask

   task automatic step(input string tag, input logic cen, input logic wen,
                       input logic [WIDTH-1:0] din, input logic fl);
      int d;
      int lag;
      clk_en    = cen;
      wen_in    = wen;
      data_in   = din;
      flush     = fl;
      config_en = 1'b0;
      @(posedge clk_in);
      #1;
      if (cen) begin
         d = eff_depth();
         if (fl) begin
            m_n     = 0;
            m_valid = '0;
         end else if (m_cfg[2] && m_cfg[1:0] == 2'b00 && wen) begin
            m_n++;
            m_hist[m_n & 4095] = din;
            for (int k = 0; k < NUM_TAPS; k++) begin
               lag = (k + 1) * d;
               if (m_n - 1 >= lag) begin
                  m_valid[k] = 1'b1;
                  m_data[k]  = m_hist[(m_n - lag) & 4095];
                  m_known[k] = 1'b1;
               end else begin
                  m_valid[k] = 1'b0;
                  m_known[k] = 1'b0;
               end
            end
         end else if (m_cfg[2] && m_cfg[1:0] == 2'b01) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
               m_valid[k] = wen;
               m_data[k]  = din;
               m_known[k] = 1'b1;
            end
         end else begin
            m_valid = '0;
         end
      end
      check_state(tag);
   endtask

   task automatic cfg_write(input string tag, input logic [31:0] val, input logic cen,
                            input logic wen, input logic [WIDTH-1:0] din);
      config_en   = 1'b1;
      config_addr = 32'h0000_0000;
      config_data = val;
      clk_en      = cen;
      wen_in      = wen;
      data_in     = din;
      flush       = 1'b0;
      @(posedge clk_in);
      #1;
      config_en = 1'b0;
      m_cfg     = val[15:0];
      m_n       = 0;
      if (cen) m_valid = '0;
      check_state(tag);
   endtask

   task automatic read_check(input string tag, input logic [7:0] sel, input logic rd_en);
      config_read = rd_en;
      config_addr = {sel, 24'h00_0000};
      #1;
      check(tag, read_data, (rd_en && sel == 8'd0) ? {16'h0000, m_cfg} : 32'h0000_0000);
      config_read = 1'b0;
      config_addr = 32'h0000_0000;
   endtask

   initial begin
      reset       = 1'b0;
      clk_en      = 1'b0;
      config_en   = 1'b0;
      config_read = 1'b0;
      config_addr = 32'h0;
      config_data = 32'h0;
      data_in     = '0;
      wen_in      = 1'b0;
      flush       = 1'b0;
      model_reset();

      // Reset state
      repeat (2) @(posedge clk_in);
      #1;
      check_state("reset");
      read_check("reset.rd", 8'd0, 1'b1);
      @(negedge clk_in);
      reset = 1'b1;

      // Incrementing stream, depth 10
      cfg_write("cfg_d10", 32'h0000_0054, 1'b1, 1'b0, '0);
      read_check("rd_cfg", 8'd0, 1'b1);
      for (int i = 1; i <= 25; i++) begin
         step($sformatf("inc%0d", i), 1'b1, 1'b1, WIDTH'(i), 1'b0);
      end

      // Config write with a simultaneous push: the push is dropped
      cfg_write("cfg_vs_push", 32'h0000_0054, 1'b1, 1'b1, 16'hBEEF);

      // Gapped writes
      for (int i = 0; i < 60; i++) begin
         step($sformatf("gap%0d", i), 1'b1,
              (i < 15) || (i >= 21 && i < 40) || (i > 45), WIDTH'($urandom), 1'b0);
      end

      // Three-cycle flush with wen held high, then refill
      for (int i = 0; i < 3; i++) begin
         step($sformatf("flush%0d", i), 1'b1, 1'b1, WIDTH'($urandom), 1'b1);
      end
      for (int i = 0; i < 25; i++) begin
         step($sformatf("refill%0d", i), 1'b1, 1'b1, WIDTH'($urandom), 1'b0);
      end

      // Clock enable low mid-stream
      for (int i = 0; i < 5; i++) begin
         step($sformatf("cen0_%0d", i), 1'b0, 1'b1, WIDTH'($urandom), 1'b0);
      end
      read_check("rd_frozen", 8'd0, 1'b1);
      read_check("rd_reserved", 8'd1, 1'b1);
      read_check("rd_disabled", 8'd0, 1'b0);
      for (int i = 0; i < 15; i++) begin
         step($sformatf("resume%0d", i), 1'b1, 1'b1, WIDTH'($urandom), 1'b0);
      end

      // Tile disabled: no pushes, outputs hold
      cfg_write("cfg_tile_off", 32'h0000_0050, 1'b1, 1'b0, '0);
      for (int i = 0; i < 4; i++) begin
         step($sformatf("tile_off%0d", i), 1'b1, 1'b1, WIDTH'($urandom), 1'b0);
      end

      // Randomised traffic over short depths
      for (int i = 0; i < 300; i++) begin
         if (i % 60 == 0) begin
            cfg_write("rnd_cfg", {16'h0000, 13'($urandom_range(0, 6)), 1'b1, 2'b00},
                      1'($urandom_range(0, 1)), 1'b1, WIDTH'($urandom));
         end else begin
            step("rnd", ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0),
                 WIDTH'($urandom), ($urandom_range(0, 19) == 0));
         end
      end

      // Depth 0 behaves as depth 1
      cfg_write("cfg_d0", 32'h0000_0004, 1'b1, 1'b0, '0);
      for (int i = 0; i < 6; i++) begin
         step($sformatf("d0_%0d", i), 1'b1, 1'b1, WIDTH'($urandom), 1'b0);
      end

      // Maximum depth: pointer wraps 1023 -> 0, tap 0 valid from push 1025
      cfg_write("cfg_dmax", 32'h0000_2004, 1'b1, 1'b0, '0);
      for (int i = 1; i <= 1030; i++) begin
         step("dmax", 1'b1, 1'b1, WIDTH'($urandom), 1'b0);
      end

      // Asynchronous reset mid-fill
      cfg_write("cfg_d4", 32'h0000_0024, 1'b1, 1'b0, '0);
      for (int i = 0; i < 10; i++) begin
         step($sformatf("pre_rst%0d", i), 1'b1, 1'b1, WIDTH'($urandom), 1'b0);
      end
      wen_in = 1'b1;
      reset  = 1'b0;
      model_reset();
      #1;
      check_state("async_rst");
      read_check("async_rst.rd", 8'd0, 1'b1);
      @(negedge clk_in);
      reset = 1'b1;
      step("post_rst", 1'b1, 1'b1, WIDTH'($urandom), 1'b0);
      cfg_write("cfg_d4b", 32'h0000_0024, 1'b1, 1'b0, '0);
      for (int i = 0; i < 10; i++) begin
         step($sformatf("refill_rst%0d", i), 1'b1, 1'b1, WIDTH'($urandom), 1'b0);
      end

      // Bypass mode
      cfg_write("cfg_bypass", 32'h0000_0055, 1'b1, 1'b0, '0);
      for (int i = 0; i < 6; i++) begin
         step($sformatf("bypass%0d", i), 1'b1, (i != 3), WIDTH'($urandom), 1'b0);
      end

      // Reserved mode idles
      cfg_write("cfg_idle", 32'h0000_0056, 1'b1, 1'b0, '0);
      for (int i = 0; i < 3; i++) begin
         step($sformatf("idle%0d", i), 1'b1, 1'b1, WIDTH'($urandom), 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
